mul_div_unit: RTL and testbench

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

---
 rtl/mul_div_pkg.sv | 26 ++
 rtl/mul_div_sign_cond.sv | 44 ++++
 rtl/mul_div_unit.sv | 225 ++++++++++++++++++++++
 tb/tb_mul_div_unit.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_div_pkg.sv
// Shared definitions for the multiply/divide unit.
//   op codes      : MULT, MULTU, DIV, DIVU, MTHI, MTLO (6-7 reserved)
//   state_e       : controller states IDLE, MUL, DIV, FIN
//   cnt_width()   : iteration-counter width for a given operand width
package mul_div_pkg;

  localparam logic [2:0] OpMult  = 3'd0;
  localparam logic [2:0] OpMultu = 3'd1;
  localparam logic [2:0] OpDiv   = 3'd2;
  localparam logic [2:0] OpDivu  = 3'd3;
  localparam logic [2:0] OpMthi  = 3'd4;
  localparam logic [2:0] OpMtlo  = 3'd5;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StMul  = 2'd1,
    StDiv  = 2'd2,
    StFin  = 2'd3
  } state_e;

  // Counter holds 0 .. width-1.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/mul_div_sign_cond.sv
// Sign conditioning for the multiply/divide unit (purely combinational).
//   signed_i        : operation treats operands as two's complement
//   a_i, b_i        : raw operands
//   a_neg_o/b_neg_o : operand is negative (only when signed_i)
//   a_mag_o/b_mag_o : operand magnitudes
//   res_i           : unsigned result {hi, lo}
//   neg_full_i      : negate the full double-width result (product)
//   neg_hi_i        : negate the upper half only (remainder)
//   neg_lo_i        : negate the lower half only (quotient)
//   res_o           : sign-corrected result
module mul_div_sign_cond #(
  parameter int unsigned Width = 32
) (
  input  logic               signed_i,
  input  logic [Width-1:0]   a_i,
  input  logic [Width-1:0]   b_i,
  output logic               a_neg_o,
  output logic               b_neg_o,
  output logic [Width-1:0]   a_mag_o,
  output logic [Width-1:0]   b_mag_o,
  input  logic [2*Width-1:0] res_i,
  input  logic               neg_full_i,
  input  logic               neg_hi_i,
  input  logic               neg_lo_i,
  output logic [2*Width-1:0] res_o
);

  assign a_neg_o = signed_i & a_i[Width-1];
  assign b_neg_o = signed_i & b_i[Width-1];
  // The most-negative value maps onto itself, which is its correct unsigned magnitude.
  assign a_mag_o = a_neg_o ? -a_i : a_i;
  assign b_mag_o = b_neg_o ? -b_i : b_i;

  always_comb begin
    res_o = res_i;
    if (neg_full_i) begin
      res_o = -res_i;
    end else begin
      if (neg_hi_i) res_o[2*Width-1:Width] = -res_i[2*Width-1:Width];
      if (neg_lo_i) res_o[Width-1:0] = -res_i[Width-1:0];
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit with HI/LO result registers.
//   clock, reset  : rising-edge clock, asynchronous active-high reset
//   start, op     : request strobe and op code (see mul_div_pkg)
//   a, b          : operands (a is also the MTHI/MTLO source)
//   busy          : iterative op in flight
//   done          : one-cycle completion pulse
//   hi, lo        : result registers
//   div_zero      : divide by zero, valid in the done cycle only
// Define MUL_DIV_UNIT_DIV_EN to build the restoring divider; without it DIV/DIVU
// complete in one cycle and leave HI/LO untouched.
module mul_div_unit
  import mul_div_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  localparam int unsigned     CntW    = cnt_width(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;    // {partial product, multiplier} or {remainder, dividend}
  logic [WIDTH-1:0]   opnd_q, opnd_d;  // multiplicand or divisor magnitude
  logic               neg_full_q, neg_full_d;
  logic               neg_hi_q, neg_hi_d;
  logic               neg_lo_q, neg_lo_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;
  logic               div_zero_q, div_zero_d;

  logic               op_signed, a_neg, b_neg, mt_hit;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_step, step_res, final_res;

  assign op_signed = (op == OpMult) || (op == OpDiv);

  mul_div_sign_cond #(
    .Width(WIDTH)
  ) u_sign_cond (
    .signed_i  (op_signed),
    .a_i       (a),
    .b_i       (b),
    .a_neg_o   (a_neg),
    .b_neg_o   (b_neg),
    .a_mag_o   (a_mag),
    .b_mag_o   (b_mag),
    .res_i     (step_res),
    .neg_full_i(neg_full_q),
    .neg_hi_i  (neg_hi_q),
    .neg_lo_i  (neg_lo_q),
    .res_o     (final_res)
  );

  // Shift-add: add multiplicand to the upper half when the multiplier LSB is set, shift right.
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + ({(WIDTH+1){acc_q[0]}} & {1'b0, opnd_q});
  assign mul_step = {mul_sum, acc_q[WIDTH-1:1]};

`ifdef MUL_DIV_UNIT_DIV_EN
  logic [WIDTH-1:0]   a_q, a_d;        // raw dividend, returned as HI on divide by zero
  logic               dz_q, dz_d;
  logic [WIDTH:0]     div_shift, div_diff;
  logic [2*WIDTH-1:0] div_step;

  // Restoring step: shift next dividend bit into the remainder, keep the difference if no borrow.
  assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opnd_q};
  assign div_step  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                     : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
  assign step_res  = (state_q == StDiv) ? div_step : mul_step;
`else
  assign step_res  = mul_step;
`endif

  // Moves are also accepted in FIN so they can follow a completion back-to-back.
  assign mt_hit = start && ((state_q == StIdle) || (state_q == StFin)) &&
                  ((op == OpMthi) || (op == OpMtlo));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    opnd_d     = opnd_q;
    neg_full_d = neg_full_q;
    neg_hi_d   = neg_hi_q;
    neg_lo_d   = neg_lo_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    div_zero_d = 1'b0;
`ifdef MUL_DIV_UNIT_DIV_EN
    a_d        = a_q;
    dz_d       = dz_q;
`endif

    if (mt_hit) begin
      done_d = 1'b1;
      if (op == OpMthi) hi_d = a;
      else              lo_d = a;
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          case (op)
            OpMult, OpMultu: begin
              state_d    = StMul;
              cnt_d      = '0;
              acc_d      = {{WIDTH{1'b0}}, b_mag};
              opnd_d     = a_mag;
              neg_full_d = a_neg ^ b_neg;
              neg_hi_d   = 1'b0;
              neg_lo_d   = 1'b0;
            end
            OpDiv, OpDivu: begin
`ifdef MUL_DIV_UNIT_DIV_EN
              state_d    = StDiv;
              cnt_d      = '0;
              acc_d      = {{WIDTH{1'b0}}, a_mag};
              opnd_d     = b_mag;
              neg_full_d = 1'b0;
              neg_hi_d   = a_neg;
              neg_lo_d   = a_neg ^ b_neg;
              a_d        = a;
              dz_d       = (b == '0);
`else
              done_d     = 1'b1;
`endif
            end
            default: ;
          endcase
        end
      end
      StMul: begin
        acc_d = step_res;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) begin
          state_d = StFin;
          cnt_d   = '0;
          done_d  = 1'b1;
          hi_d    = final_res[2*WIDTH-1:WIDTH];
          lo_d    = final_res[WIDTH-1:0];
        end
      end
      StDiv: begin
`ifdef MUL_DIV_UNIT_DIV_EN
        acc_d = step_res;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) begin
          state_d = StFin;
          cnt_d   = '0;
          done_d  = 1'b1;
          if (dz_q) begin
            hi_d       = a_q;
            lo_d       = '1;
            div_zero_d = 1'b1;
          end else begin
            hi_d = final_res[2*WIDTH-1:WIDTH];
            lo_d = final_res[WIDTH-1:0];
          end
        end
`else
        state_d = StIdle;
`endif
      end
      StFin: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      acc_q      <= '0;
      opnd_q     <= '0;
      neg_full_q <= 1'b0;
      neg_hi_q   <= 1'b0;
      neg_lo_q   <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
`ifdef MUL_DIV_UNIT_DIV_EN
      a_q        <= '0;
      dz_q       <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      opnd_q     <= opnd_d;
      neg_full_q <= neg_full_d;
      neg_hi_q   <= neg_hi_d;
      neg_lo_q   <= neg_lo_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
`ifdef MUL_DIV_UNIT_DIV_EN
      a_q        <= a_d;
      dz_q       <= dz_d;
`endif
    end
  end

  assign busy     = (state_q == StMul) || (state_q == StDiv);
  assign done     = done_q;
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign div_zero = div_zero_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit (WIDTH = 32): directed vector table, hand-written
// multi-cycle sequences and random ops against an arithmetic reference model.
module tb_mul_div_unit;

  localparam int W   = 32;
  localparam int Lat = W + 1;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [2:0]    op    = '0;
  logic [W-1:0]  a     = '0;
  logic [W-1:0]  b     = '0;
  logic          busy, done, div_zero;
  logic [W-1:0]  hi, lo;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] ref_hi = '0;
  logic [W-1:0] ref_lo = '0;

  typedef struct {
    string      name;
    logic [2:0] op;
    logic [31:0] a, b, hi, lo;
    logic       dz;
    int         lat;
  } vec_t;
  vec_t vecs[$];

  mul_div_unit #(.WIDTH(W)) dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo),
    .div_zero(div_zero)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic void add_vec(input string name, input logic [2:0] o, input logic [31:0] av,
                                  input logic [31:0] bv, input logic [31:0] eh,
                                  input logic [31:0] el, input logic edz, input int lat);
    vec_t v;
    v.name = name; v.op = o; v.a = av; v.b = bv; v.hi = eh; v.lo = el; v.dz = edz; v.lat = lat;
    vecs.push_back(v);
  endfunction

  // Reference model: plain arithmetic on the current HI/LO state.
  function automatic void model(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                                output logic [31:0] eh, output logic [31:0] el,
                                output logic edz, output int lat);
    logic [63:0] p;
    longint sa, sb;
    eh = ref_hi; el = ref_lo; edz = 1'b0; lat = 1;
    sa = longint'($signed(av));
    sb = longint'($signed(bv));
    case (o)
      3'd0: begin p = 64'(sa * sb); {eh, el} = p; lat = Lat; end
      3'd1: begin p = {32'd0, av} * {32'd0, bv}; {eh, el} = p; lat = Lat; end
      3'd2, 3'd3: begin
`ifdef MUL_DIV_UNIT_DIV_EN
        lat = Lat;
        if (bv == 0) begin
          eh = av; el = '1; edz = 1'b1;
        end else if (o == 3'd2) begin
          el = 32'(sa / sb); eh = 32'(sa % sb);
        end else begin
          el = av / bv; eh = av % bv;
        end
`endif
      end
      3'd4: eh = av;
      3'd5: el = av;
      default: ;
    endcase
  endfunction

  task automatic issue(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv);
    @(negedge clock);
    start = 1'b1; op = o; a = av; b = bv;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 1;
    while (!done && n < 100) begin
      @(posedge clock); #1;
      n++;
    end
  endtask

  // Issue one op and check latency, busy, HI/LO hold, results and the single-cycle pulse.
  task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] av,
                        input logic [31:0] bv, input logic [31:0] eh, input logic [31:0] el,
                        input logic edz, input int elat);
    int n;
    bit busy_bad, hold_bad;
    busy_bad = 0; hold_bad = 0;
    issue(o, av, bv);
    n = 1;
    while (!done && n < 100) begin
      if (!busy) busy_bad = 1;
      if (hi !== ref_hi || lo !== ref_lo) hold_bad = 1;
      @(posedge clock); #1;
      n++;
    end
    check({name, " done"}, done, 1);
    check({name, " latency"}, n, elat);
    check({name, " busy while running"}, busy_bad, 0);
    check({name, " hi/lo held while busy"}, hold_bad, 0);
    check({name, " busy at done"}, busy, 0);
    check({name, " hi"}, hi, eh);
    check({name, " lo"}, lo, el);
    check({name, " div_zero"}, div_zero, edz);
    @(posedge clock); #1;
    check({name, " done one cycle"}, done, 0);
    check({name, " div_zero one cycle"}, div_zero, 0);
    ref_hi = eh;
    ref_lo = el;
  endtask

  function automatic logic [31:0] rand_opnd();
    case ($urandom_range(0, 6))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n, dcnt, dat, bcnt;
    logic [31:0] cap_hi, cap_lo, eh, el;
    logic edz;
    int elat;

    add_vec("multu max",   3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0, Lat);
    add_vec("mult -3*5",   3'd0, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, 0, Lat);
    add_vec("mthi",        3'd4, 32'h0000_3C00, 32'd9,         32'h0000_3C00, 32'hFFFF_FFF1, 0, 1);
    add_vec("mtlo",        3'd5, 32'h0000_1234, 32'd0,         32'h0000_3C00, 32'h0000_1234, 0, 1);
    add_vec("mult min*min",3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 0, Lat);
    add_vec("mult -1*1",   3'd0, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, Lat);
    add_vec("mult 7*-6",   3'd0, 32'd7,         32'hFFFF_FFFA, 32'hFFFF_FFFF, 32'hFFFF_FFD6, 0, Lat);
`ifdef MUL_DIV_UNIT_DIV_EN
    add_vec("div -7/2",    3'd2, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, Lat);
    add_vec("divu ab/0",   3'd3, 32'h0000_00AB, 32'd0,         32'h0000_00AB, 32'hFFFF_FFFF, 1, Lat);
    add_vec("div min/-1",  3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 0, Lat);
    add_vec("divu 100/7",  3'd3, 32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E, 0, Lat);
    add_vec("div 7/-2",    3'd2, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 0, Lat);
    add_vec("div -8/0",    3'd2, 32'hFFFF_FFF8, 32'd0,         32'hFFFF_FFF8, 32'hFFFF_FFFF, 1, Lat);
`else
    add_vec("div off 7/2", 3'd2, 32'd7,         32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFD6, 0, 1);
    add_vec("divu off /0", 3'd3, 32'h0000_00AB, 32'd0,         32'hFFFF_FFFF, 32'hFFFF_FFD6, 0, 1);
`endif

    // Reset state.
    repeat (3) @(posedge clock);
    #1;
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset hi", hi, 0);
    check("reset lo", lo, 0);
    check("reset div_zero", div_zero, 0);
    @(negedge clock);
    reset = 1'b0;

    foreach (vecs[i]) begin
      run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo,
             vecs[i].dz, vecs[i].lat);
    end

    // Reset ten cycles into a MULTU aborts it with no done.
    issue(3'd1, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (9) @(posedge clock);
    #2;
    check("abort busy before reset", busy, 1);
    reset = 1'b1;
    #1;
    check("abort busy", busy, 0);
    check("abort hi", hi, 0);
    check("abort lo", lo, 0);
    check("abort done", done, 0);
    @(negedge clock);
    reset = 1'b0;
    dcnt = 0; bcnt = 0;
    repeat (40) begin
      @(posedge clock); #1;
      if (done) dcnt++;
      if (busy) bcnt++;
    end
    check("abort no done", dcnt, 0);
    check("abort stays idle", bcnt, 0);
    ref_hi = '0; ref_lo = '0;

    // DIVU strobe during a MULTU is ignored.
    issue(3'd1, 32'd12345, 32'd678);
    n = 1; dcnt = 0; dat = 0; cap_hi = '0; cap_lo = '0;
    while (n < 80) begin
      if (done) begin dcnt++; dat = n; cap_hi = hi; cap_lo = lo; end
      @(negedge clock);
      if (n == 5) begin start = 1'b1; op = 3'd3; a = 32'd100; b = 32'd0; end
      else start = 1'b0;
      @(posedge clock); #1;
      n++;
    end
    start = 1'b0;
    model(3'd1, 32'd12345, 32'd678, eh, el, edz, elat);
    check("overlap done count", dcnt, 1);
    check("overlap latency", dat, elat);
    check("overlap hi", cap_hi, eh);
    check("overlap lo", cap_lo, el);
    check("overlap div_zero", div_zero, 0);
    ref_hi = eh; ref_lo = el;

    // MTLO accepted in the done cycle of a MULTU.
    issue(3'd1, 32'd3, 32'd4);
    wait_done(n);
    check("b2b mul latency", n, Lat);
    check("b2b mul lo", lo, 32'd12);
    start = 1'b1; op = 3'd5; a = 32'h55; b = '0;
    @(posedge clock); #1;
    start = 1'b0;
    check("b2b mtlo done", done, 1);
    check("b2b mtlo lo", lo, 32'h55);
    check("b2b mtlo hi", hi, 0);
    check("b2b mtlo busy", busy, 0);
    @(posedge clock); #1;
    check("b2b mtlo one pulse", done, 0);
    ref_hi = '0; ref_lo = 32'h55;

    // Iterative start in FIN is ignored.
    issue(3'd0, 32'd2, 32'd3);
    wait_done(n);
    check("fin mult lo", lo, 32'd6);
    start = 1'b1; op = 3'd1; a = 32'd5; b = 32'd5;
    @(posedge clock); #1;
    start = 1'b0;
    dcnt = 0; bcnt = 0;
    repeat (40) begin
      if (done) dcnt++;
      if (busy) bcnt++;
      @(posedge clock); #1;
    end
    check("fin start ignored done", dcnt, 0);
    check("fin start ignored busy", bcnt, 0);
    check("fin start ignored lo", lo, 32'd6);
    ref_hi = '0; ref_lo = 32'd6;

    // Reserved op produces nothing.
    issue(3'd6, 32'hDEAD_BEEF, 32'd1);
    dcnt = 0; bcnt = 0;
    repeat (40) begin
      if (done) dcnt++;
      if (busy) bcnt++;
      @(posedge clock); #1;
    end
    check("reserved no done", dcnt, 0);
    check("reserved no busy", bcnt, 0);
    check("reserved hi", hi, ref_hi);
    check("reserved lo", lo, ref_lo);

    // Random ops against the reference model.
    for (int i = 0; i < 40; i++) begin
      logic [2:0] ro;
      logic [31:0] ra, rb;
      ro = 3'($urandom_range(0, 5));
      ra = rand_opnd();
      rb = rand_opnd();
      model(ro, ra, rb, eh, el, edz, elat);
      run_op($sformatf("rand%0d op%0d", i, ro), ro, ra, rb, eh, el, edz, elat);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
